sensor_hit_capture: RTL and testbench

Conditions the raw 3-bit box code the Arduino drives onto GPIO_1 into clean, single hit events for the game datapath. It sits directly upstream of the game-logic datapath, between the GPIO pins and the score/sound logic. Each physical strike produces exactly one hit, instead of a level that stays true for every clock the box is held. The block synchronises the input, debounces press and release, and presents hits through a valid/ready holding register. It also tracks a stable box code for HEX display and a saturating hit counter.

---
 rtl/sensor_hit_capture_if.sv | 19 +
 rtl/sensor_hit_capture.sv | 170 +++++++++++++++++
 tb/tb_sensor_hit_capture.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_hit_capture_if.sv
// Hit handshake between the sensor conditioner and the game datapath.
// The producer holds hit_box/hit_valid until the consumer raises hit_ready.
interface sensor_hit_capture_if;
    logic       hit_valid;
    logic [2:0] hit_box;
    logic       hit_ready;

    modport master (
        output hit_valid,
        output hit_box,
        input  hit_ready
    );

    modport slave (
        input  hit_valid,
        input  hit_box,
        output hit_ready
    );
endinterface

// File: rtl/sensor_hit_capture.sv
// Turns the raw 3-bit box code from the GPIO pins into one clean hit per strike:
// 2-flop synchroniser, press/release debounce FSM, and a valid/ready hit register.
module sensor_hit_capture #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [2:0]          sensor_raw,
    input  logic                enable,
    sensor_hit_capture_if.master hit_if,
    output logic [2:0]          stable_box,
    output logic [7:0]          hit_count,
    output logic                overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUALIFY,
        S_PRESSED,
        S_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       r_sync_meta;
    logic [2:0]       r_sync_q;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_cand;
    logic [2:0]       w_cand_nxt;
    logic [2:0]       r_stable_box;
    logic [2:0]       w_stable_nxt;
    logic             w_press_done;
    logic             w_hit_gen;

    logic             r_hit_valid;
    logic [2:0]       r_hit_box;
    logic [7:0]       r_hit_count;
    logic             r_overflow;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sync_meta <= 3'd0;
            r_sync_q    <= 3'd0;
        end else begin
            r_sync_meta <= sensor_raw;
            r_sync_q    <= r_sync_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_cand       <= 3'd0;
            r_stable_box <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cand       <= w_cand_nxt;
            r_stable_box <= w_stable_nxt;
        end
    end

    // The counter holds the number of qualifying samples already seen, so the
    // sample that would make it DEBOUNCE_CYCLES takes the transition directly.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cand_nxt   = r_cand;
        w_stable_nxt = r_stable_box;
        w_press_done = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (r_sync_q != 3'd0) begin
                    w_state_nxt = S_QUALIFY;
                    w_cand_nxt  = r_sync_q;
                    w_cnt_nxt   = LP_ONE;
                end
            end

            S_QUALIFY: begin
                if (r_sync_q == 3'd0) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_sync_q != r_cand) begin
                    w_cand_nxt  = r_sync_q;
                    w_cnt_nxt   = LP_ONE;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nxt  = S_PRESSED;
                    w_stable_nxt = r_cand;
                    w_press_done = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end

            S_PRESSED: begin
                if (r_sync_q != r_cand) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = (r_sync_q == 3'd0) ? LP_ONE : '0;
                end
            end

            S_RELEASE: begin
                if (r_sync_q == r_cand) begin
                    w_state_nxt = S_PRESSED;
                end else if (r_sync_q == 3'd0) begin
                    if (r_cnt == LP_LAST) begin
                        w_state_nxt  = S_IDLE;
                        w_stable_nxt = 3'd0;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                end else begin
                    // Sliding onto another box restarts the release count only.
                    w_cnt_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_hit_gen = w_press_done & enable;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_hit_valid <= 1'b0;
            r_hit_box   <= 3'd0;
            r_hit_count <= 8'd0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_hit_gen) begin
                // A held hit being accepted this same edge frees the slot.
                if (!r_hit_valid || hit_if.hit_ready) begin
                    r_hit_valid <= 1'b1;
                    r_hit_box   <= r_cand;
                    if (r_hit_count != 8'hFF) begin
                        r_hit_count <= r_hit_count + 8'd1;
                    end
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_hit_valid && hit_if.hit_ready) begin
                r_hit_valid <= 1'b0;
            end
        end
    end

    assign hit_if.hit_valid = r_hit_valid;
    assign hit_if.hit_box   = r_hit_box;
    assign stable_box       = r_stable_box;
    assign hit_count        = r_hit_count;
    assign overflow         = r_overflow;

endmodule

// File: tb/tb_sensor_hit_capture.sv
// Bench for sensor_hit_capture: directed strike scenarios plus random sensor
// traffic, all compared every cycle against a run-length based reference model.
module tb_sensor_hit_capture;

    localparam int D = 4;

    logic       clk    = 1'b0;
    logic       resetn = 1'b1;
    logic [2:0] sensor_raw = 3'd0;
    logic       enable = 1'b0;
    logic [2:0] stable_box;
    logic [7:0] hit_count;
    logic       overflow;

    sensor_hit_capture_if sif ();

    sensor_hit_capture #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .sensor_raw(sensor_raw),
        .enable    (enable),
        .hit_if    (sif),
        .stable_box(stable_box),
        .hit_count (hit_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the FSM sees is the raw input two edges late; a press
    // is a nonzero code seen D times in a row while nothing is pressed, a release
    // is D zero samples in a row while a box is pressed.
    int m_d1, m_d2;
    int m_run_val, m_run_len;
    int m_stable;
    int m_valid, m_box, m_count, m_ovf;

    int edge_no;
    int hits_seen;
    int last_hit_edge;
    int fall_edge;
    int prev_stable;
    int hit_boxes[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0;
        m_run_val = 0; m_run_len = 0;
        m_stable = 0;
        m_valid = 0; m_box = 0; m_count = 0; m_ovf = 0;
    endtask

    task automatic model_edge();
        int x;
        int fire;
        x = m_d2;
        if (x == m_run_val) m_run_len++;
        else begin
            m_run_val = x;
            m_run_len = 1;
        end
        fire = 0;
        if (m_stable == 0 && x != 0 && m_run_len == D) begin
            m_stable = x;
            fire = int'(enable);
        end else if (m_stable != 0 && x == 0 && m_run_len == D) begin
            m_stable = 0;
        end
        if (fire != 0) begin
            if (m_valid == 0 || sif.hit_ready) begin
                m_valid = 1;
                m_box   = x;
                if (m_count < 255) m_count++;
            end else begin
                m_ovf = 1;
            end
        end else if (m_valid != 0 && sif.hit_ready) begin
            m_valid = 0;
        end
        m_d2 = m_d1;
        m_d1 = int'(sensor_raw);
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, ".hit_valid"},  32'(sif.hit_valid), m_valid);
        check({pfx, ".hit_box"},    32'(sif.hit_box),   m_box);
        check({pfx, ".stable_box"}, 32'(stable_box),    m_stable);
        check({pfx, ".hit_count"},  32'(hit_count),     m_count);
        check({pfx, ".overflow"},   32'(overflow),      m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        edge_no++;
        check_outputs("cyc");
        if (sif.hit_valid && sif.hit_ready) begin
            hits_seen++;
            hit_boxes.push_back(int'(sif.hit_box));
            last_hit_edge = edge_no;
        end
        if (prev_stable != 0 && stable_box == 3'd0) fall_edge = edge_no;
        prev_stable = int'(stable_box);
    endtask

    task automatic run(input logic [2:0] v, input int n);
        sensor_raw = v;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input logic [2:0] hold_raw, input logic [2:0] after_raw);
        resetn     = 1'b0;
        sensor_raw = hold_raw;
        model_reset();
        #1;
        check_outputs("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_outputs("rst_hold");
        sensor_raw    = after_raw;
        resetn        = 1'b1;
        edge_no       = 0;
        hits_seen     = 0;
        last_hit_edge = -1;
        fall_edge     = -1;
        prev_stable   = 0;
        hit_boxes.delete();
    endtask

    function automatic int first_box();
        return (hit_boxes.size() > 0) ? hit_boxes[0] : -1;
    endfunction

    function automatic int last_box();
        return (hit_boxes.size() > 0) ? hit_boxes[hit_boxes.size()-1] : -1;
    endfunction

    initial begin
        int press_edge;
        int rel_edge;
        logic [2:0] v;

        sif.hit_ready = 1'b1;
        #2;

        // Reset and idle with a box driven during reset.
        enable = 1'b1;
        do_reset(3'd5, 3'd0);
        run(3'd0, 20);
        check("s1_no_hits", hits_seen, 0);

        // Clean press of box 3 starting at edge 10.
        do_reset(3'd0, 3'd0);
        run(3'd0, 9);
        press_edge = edge_no + 1;
        run(3'd3, 20);
        check("s2_hits", hits_seen, 1);
        check("s2_hit_edge", last_hit_edge, press_edge + D + 1);
        check("s2_hit_box", first_box(), 3);
        check("s2_stable_held", 32'(stable_box), 3);
        rel_edge = edge_no + 1;
        run(3'd0, 10);
        check("s2_release_edge", fall_edge, rel_edge + D + 1);
        check("s2_count", 32'(hit_count), 1);

        // Bounce rejection followed by a solid hold.
        do_reset(3'd0, 3'd0);
        run(3'd0, 3);
        for (int i = 0; i < 4; i++) begin
            run(3'd3, 2);
            run(3'd0, 2);
        end
        press_edge = edge_no + 1;
        run(3'd3, 10);
        check("s3_hits", hits_seen, 1);
        check("s3_hit_edge", last_hit_edge, press_edge + D + 1);
        check("s3_count", 32'(hit_count), 1);

        // Slide 2->6->2 without release, then a real release and re-press.
        do_reset(3'd0, 3'd0);
        run(3'd2, D + 4);
        run(3'd6, 3);
        run(3'd2, 3);
        run(3'd0, D + 2);
        run(3'd2, D + 4);
        run(3'd0, D + 4);
        check("s4_hits", hits_seen, 2);
        check("s4_box_a", first_box(), 2);
        check("s4_box_b", last_box(), 2);

        // Backpressure: second strike is dropped and flagged.
        do_reset(3'd0, 3'd0);
        sif.hit_ready = 1'b0;
        run(3'd1, D + 4);
        run(3'd0, D + 4);
        run(3'd4, D + 4);
        run(3'd0, D + 4);
        check("s5_valid_held", 32'(sif.hit_valid), 1);
        check("s5_box_held", 32'(sif.hit_box), 1);
        check("s5_overflow", 32'(overflow), 1);
        check("s5_count", 32'(hit_count), 1);
        sif.hit_ready = 1'b1;
        step();
        sif.hit_ready = 1'b0;
        check("s5_valid_drop", 32'(sif.hit_valid), 0);
        run(3'd0, 3);
        check("s5_overflow_sticky", 32'(overflow), 1);
        sif.hit_ready = 1'b1;

        // Enable gating: a box already held when enable rises never fires.
        do_reset(3'd0, 3'd0);
        enable = 1'b0;
        run(3'd7, D + 4);
        enable = 1'b1;
        run(3'd7, 8);
        check("s6_no_hit", hits_seen, 0);
        check("s6_stable", 32'(stable_box), 7);
        run(3'd0, D + 2);
        run(3'd7, D + 4);
        run(3'd0, D + 4);
        check("s6_hits", hits_seen, 1);
        check("s6_box", first_box(), 7);

        // Mid-press reset: pending qualification is lost, held box re-qualifies.
        do_reset(3'd0, 3'd0);
        run(3'd5, D);
        do_reset(3'd5, 3'd5);
        run(3'd5, D + 4);
        check("s7_requalify_hits", hits_seen, 1);
        check("s7_box", first_box(), 5);

        // Random traffic with random enable, backpressure and occasional resets.
        do_reset(3'd0, 3'd0);
        for (int seg = 0; seg < 300; seg++) begin
            v = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            sif.hit_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) do_reset(sensor_raw, sensor_raw);
            run(v, $urandom_range(1, 2 * D + 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
